// File: rtl/id_ex_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: memory size codes,
// a few ALU op codes, and the per-edge update action of the register.
package id_ex_reg_pkg;

   localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
   localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
   localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

   localparam logic [7:0] ALU_OP_NOP = 8'h00;
   localparam logic [7:0] ALU_OP_ADD = 8'h01;
   localparam logic [7:0] ALU_OP_SUB = 8'h02;
   localparam logic [7:0] ALU_OP_AND = 8'h03;
   localparam logic [7:0] ALU_OP_OR  = 8'h04;

   typedef enum logic [1:0] {
      UPD_CAPTURE = 2'd0,
      UPD_HOLD    = 2'd1,
      UPD_BUBBLE  = 2'd2
   } upd_e;

   // A register write to $0 has no architectural effect and must not create hazards.
   function automatic logic wb_effective(input logic wb_en, input logic [4:0] wb_reg);
      return wb_en & (wb_reg != 5'd0);
   endfunction

endpackage

// File: rtl/id_ex_reg_load_use_detect.sv
// Combinational load-use hazard comparator: flags an ID instruction that reads
// the destination of a load currently sitting in EX.
module load_use_detect #(
   parameter int REG_W = 5
) (
   input  logic             ex_valid,
   input  logic             ex_mem_read,
   input  logic             ex_wb_en,
   input  logic [REG_W-1:0] ex_wb_reg,
   input  logic             id_valid,
   input  logic             id_rs_read,
   input  logic [REG_W-1:0] id_rs,
   input  logic             id_rt_read,
   input  logic [REG_W-1:0] id_rt,
   output logic             load_use_stall
);

   logic ex_is_load;
   logic rs_hit;
   logic rt_hit;

   assign ex_is_load = ex_valid & ex_mem_read & ex_wb_en & (ex_wb_reg != '0);
   assign rs_hit     = id_rs_read & (id_rs == ex_wb_reg);
   assign rt_hit     = id_rt_read & (id_rt == ex_wb_reg);

   assign load_use_stall = ex_is_load & id_valid & (rs_hit | rt_hit);

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall/bubble/flush and load-use stall request.
// Optional macro IDEX_PERF_CNT_EN adds perf_bubbles / perf_flushes counters.
module id_ex_reg
   import id_ex_reg_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int REG_W   = 5,
   parameter int ALUOP_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall_id,
   input  logic               stall_ex,
   input  logic               flush,
   input  logic               id_valid,
   input  logic [ADDR_W-1:0]  id_addr,
   input  logic [DATA_W-1:0]  id_operand_1,
   input  logic [DATA_W-1:0]  id_operand_2,
   input  logic [ALUOP_W-1:0] id_alu_op,
   input  logic               id_mem_read,
   input  logic               id_mem_write,
   input  logic [1:0]         id_mem_size,
   input  logic               id_mem_sign,
   input  logic [DATA_W-1:0]  id_store_data,
   input  logic               id_wb_en,
   input  logic [REG_W-1:0]   id_wb_reg,
   input  logic               id_rs_read,
   input  logic [REG_W-1:0]   id_rs,
   input  logic               id_rt_read,
   input  logic [REG_W-1:0]   id_rt,
   output logic               ex_valid,
   output logic [ADDR_W-1:0]  ex_addr,
   output logic [DATA_W-1:0]  ex_operand_1,
   output logic [DATA_W-1:0]  ex_operand_2,
   output logic [ALUOP_W-1:0] ex_alu_op,
   output logic               ex_mem_read,
   output logic               ex_mem_write,
   output logic [1:0]         ex_mem_size,
   output logic               ex_mem_sign,
   output logic [DATA_W-1:0]  ex_store_data,
   output logic               ex_wb_en,
   output logic [REG_W-1:0]   ex_wb_reg,
`ifdef IDEX_PERF_CNT_EN
   output logic [31:0]        perf_bubbles,
   output logic [31:0]        perf_flushes,
`endif
   output logic               load_use_stall
);

   upd_e upd;

   // Priority: flush beats stall_ex (hold) beats stall_id (bubble). An invalid
   // ID slot is loaded as a full bubble so the ex_valid=0 invariant holds.
   always_comb begin
      upd = UPD_CAPTURE;
      if (flush)
         upd = UPD_BUBBLE;
      else if (stall_ex)
         upd = UPD_HOLD;
      else if (stall_id || !id_valid)
         upd = UPD_BUBBLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid      <= 1'b0;
         ex_addr       <= '0;
         ex_operand_1  <= '0;
         ex_operand_2  <= '0;
         ex_alu_op     <= '0;
         ex_mem_read   <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_mem_size   <= '0;
         ex_mem_sign   <= 1'b0;
         ex_store_data <= '0;
         ex_wb_en      <= 1'b0;
         ex_wb_reg     <= '0;
      end else begin
         case (upd)
            UPD_BUBBLE: begin
               ex_valid      <= 1'b0;
               ex_addr       <= '0;
               ex_operand_1  <= '0;
               ex_operand_2  <= '0;
               ex_alu_op     <= '0;
               ex_mem_read   <= 1'b0;
               ex_mem_write  <= 1'b0;
               ex_mem_size   <= '0;
               ex_mem_sign   <= 1'b0;
               ex_store_data <= '0;
               ex_wb_en      <= 1'b0;
               ex_wb_reg     <= '0;
            end
            UPD_CAPTURE: begin
               ex_valid      <= 1'b1;
               ex_addr       <= id_addr;
               ex_operand_1  <= id_operand_1;
               ex_operand_2  <= id_operand_2;
               ex_alu_op     <= id_alu_op;
               ex_mem_read   <= id_mem_read;
               ex_mem_write  <= id_mem_write;
               ex_mem_size   <= id_mem_size;
               ex_mem_sign   <= id_mem_sign;
               ex_store_data <= id_store_data;
               ex_wb_en      <= id_wb_en & (id_wb_reg != '0);
               ex_wb_reg     <= id_wb_reg;
            end
            default: ;
         endcase
      end
   end

`ifdef IDEX_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_bubbles <= '0;
         perf_flushes <= '0;
      end else begin
         if (flush)
            perf_flushes <= perf_flushes + 32'd1;
         if (!flush && !stall_ex && stall_id)
            perf_bubbles <= perf_bubbles + 32'd1;
      end
   end
`endif

   load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
      .ex_valid       (ex_valid),
      .ex_mem_read    (ex_mem_read),
      .ex_wb_en       (ex_wb_en),
      .ex_wb_reg      (ex_wb_reg),
      .id_valid       (id_valid),
      .id_rs_read     (id_rs_read),
      .id_rs          (id_rs),
      .id_rt_read     (id_rt_read),
      .id_rt          (id_rt),
      .load_use_stall (load_use_stall)
   );

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed self-checking bench for id_ex_reg: reset, pass-through, load-use,
// $0 writes, hold vs flush, and the IDEX_PERF_CNT_EN counters when enabled.
module tb_id_ex_reg;
   import id_ex_reg_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_id, stall_ex, flush;
   logic        id_valid;
   logic [31:0] id_addr, id_operand_1, id_operand_2, id_store_data;
   logic [7:0]  id_alu_op;
   logic        id_mem_read, id_mem_write, id_mem_sign, id_wb_en;
   logic [1:0]  id_mem_size;
   logic [4:0]  id_wb_reg, id_rs, id_rt;
   logic        id_rs_read, id_rt_read;
   logic        ex_valid;
   logic [31:0] ex_addr, ex_operand_1, ex_operand_2, ex_store_data;
   logic [7:0]  ex_alu_op;
   logic        ex_mem_read, ex_mem_write, ex_mem_sign, ex_wb_en;
   logic [1:0]  ex_mem_size;
   logic [4:0]  ex_wb_reg;
   logic        load_use_stall;
`ifdef IDEX_PERF_CNT_EN
   logic [31:0] perf_bubbles, perf_flushes;
`endif

   logic [31:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   id_ex_reg dut (
      .clk(clk), .rst(rst), .stall_id(stall_id), .stall_ex(stall_ex), .flush(flush),
      .id_valid(id_valid), .id_addr(id_addr), .id_operand_1(id_operand_1),
      .id_operand_2(id_operand_2), .id_alu_op(id_alu_op), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .id_mem_size(id_mem_size), .id_mem_sign(id_mem_sign),
      .id_store_data(id_store_data), .id_wb_en(id_wb_en), .id_wb_reg(id_wb_reg),
      .id_rs_read(id_rs_read), .id_rs(id_rs), .id_rt_read(id_rt_read), .id_rt(id_rt),
      .ex_valid(ex_valid), .ex_addr(ex_addr), .ex_operand_1(ex_operand_1),
      .ex_operand_2(ex_operand_2), .ex_alu_op(ex_alu_op), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_mem_size(ex_mem_size), .ex_mem_sign(ex_mem_sign),
      .ex_store_data(ex_store_data), .ex_wb_en(ex_wb_en), .ex_wb_reg(ex_wb_reg),
`ifdef IDEX_PERF_CNT_EN
      .perf_bubbles(perf_bubbles), .perf_flushes(perf_flushes),
`endif
      .load_use_stall(load_use_stall)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, expected end of test");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // advance one edge, then sample away from it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_instr(input logic v, input logic [31:0] addr, input logic [31:0] op1,
                              input logic [31:0] op2, input logic [7:0] alu,
                              input logic mrd, input logic mwr, input logic [1:0] msz,
                              input logic [31:0] sd, input logic wben, input logic [4:0] wbreg);
      id_valid = v;        id_addr = addr;     id_operand_1 = op1; id_operand_2 = op2;
      id_alu_op = alu;     id_mem_read = mrd;  id_mem_write = mwr; id_mem_size = msz;
      id_mem_sign = 1'b0;  id_store_data = sd; id_wb_en = wben;    id_wb_reg = wbreg;
   endtask

   task automatic drive_reads(input logic rsr, input logic [4:0] rs, input logic rtr, input logic [4:0] rt);
      id_rs_read = rsr; id_rs = rs; id_rt_read = rtr; id_rt = rt;
   endtask

   task automatic check_bubble(input string tag);
      check({tag, "_valid"}, ex_valid, 0);
      check({tag, "_mrd"}, ex_mem_read, 0);
      check({tag, "_wben"}, ex_wb_en, 0);
      check({tag, "_op1"}, ex_operand_1, 0);
   endtask

   initial begin
      rst = 1'b1; stall_id = 0; stall_ex = 0; flush = 0;
      drive_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive_reads(0, 0, 0, 0);
      step();
      check_bubble("reset");
      rst = 1'b0;

      // pass-through
      drive_instr(1, 32'h0040_0004, 32'h0040_0008, 32'hFFFF_8000, ALU_OP_ADD,
                  0, 0, MEM_SIZE_WORD, 32'h1234_5678, 1, 5'd5);
      exp_q.push_back(32'h0040_0008);
      exp_q.push_back(32'hFFFF_8000);
      step();
      check("pt_valid", ex_valid, 1);
      check("pt_op1", ex_operand_1, exp_q.pop_front());
      check("pt_op2", ex_operand_2, exp_q.pop_front());
      check("pt_addr", ex_addr, 32'h0040_0004);
      check("pt_wbreg", ex_wb_reg, 5);
      check("pt_wben", ex_wb_en, 1);
      check("pt_alu", ex_alu_op, ALU_OP_ADD);
      check("pt_sd", ex_store_data, 32'h1234_5678);

      // asynchronous reset mid-cycle, no clock edge in between
      #2 rst = 1'b1;
      #1;
      check_bubble("arst");
      check("arst_addr", ex_addr, 0);
      rst = 1'b0;

      // invalid ID slot with stray control bits loads a bubble
      drive_instr(0, 32'h10, 32'hAA, 32'hBB, ALU_OP_OR, 1, 1, MEM_SIZE_WORD, 0, 1, 5'd7);
      step();
      check_bubble("inv");
      check("inv_mwr", ex_mem_write, 0);

      // load-use on rs
      drive_instr(1, 32'h0040_0010, 32'h1000_0000, 32'h4, ALU_OP_ADD,
                  1, 0, MEM_SIZE_WORD, 0, 1, 5'd8);
      step();
      check("lw_mrd", ex_mem_read, 1);
      drive_instr(1, 32'h0040_0014, 32'h1, 32'h2, ALU_OP_SUB, 0, 0, 0, 0, 1, 5'd9);
      drive_reads(1, 5'd8, 0, 5'd0);
      #1 check("lu_rs", load_use_stall, 1);
      drive_reads(0, 5'd8, 1, 5'd8);
      #1 check("lu_rt", load_use_stall, 1);
      drive_reads(0, 5'd8, 0, 5'd8);
      #1 check("lu_noread", load_use_stall, 0);
      drive_reads(1, 5'd3, 1, 5'd4);
      #1 check("lu_nomatch", load_use_stall, 0);
      id_valid = 0; drive_reads(1, 5'd8, 0, 5'd0);
      #1 check("lu_idinv", load_use_stall, 0);
      id_valid = 1;
      stall_id = 1;
      step();
      check_bubble("lu_bub");
      check("lu_drop", load_use_stall, 0);
      stall_id = 0;
      exp_q.push_back(32'h0000_0009);
      step();
      check("lu_go_wbreg", ex_wb_reg, exp_q.pop_front());
      check("lu_go_valid", ex_valid, 1);

      // load to $0: wb_en dropped, no hazard
      drive_instr(1, 32'h0040_0020, 32'h2000_0000, 0, ALU_OP_ADD, 1, 0, MEM_SIZE_BYTE, 0, 1, 5'd0);
      drive_reads(0, 0, 0, 0);
      step();
      check("z_wben", ex_wb_en, 0);
      check("z_mrd", ex_mem_read, 1);
      drive_instr(1, 32'h0040_0024, 0, 0, ALU_OP_ADD, 0, 0, 0, 0, 1, 5'd2);
      drive_reads(1, 5'd0, 0, 5'd0);
      #1 check("z_lu", load_use_stall, 0);

      // hold under stall_ex, then flush beats stall_ex
      drive_instr(1, 32'h0040_0030, 32'hCAFE_0001, 32'h55, ALU_OP_AND, 0, 1, MEM_SIZE_HALF, 32'hBEEF, 0, 5'd12);
      drive_reads(0, 0, 0, 0);
      step();
      stall_ex = 1;
      for (int i = 0; i < 3; i++) begin
         drive_instr(1, 32'h100 + i, 32'h77 + i, 32'h88, ALU_OP_SUB, 0, 0, 0, 0, 1, 5'd20);
         stall_id = (i == 1);
         step();
         check("hold_op1", ex_operand_1, 32'hCAFE_0001);
         check("hold_mwr", ex_mem_write, 1);
      end
      stall_id = 0;
      flush = 1;
      step();
      check_bubble("flush_sx");
      check("flush_mwr", ex_mem_write, 0);
      stall_ex = 0;

      // extra stall_id bubbles and a flush that coincides with stall_id
      for (int i = 0; i < 3; i++) begin
         flush = 0; stall_id = 1;
         step();
         check_bubble("sid_bub");
      end
      flush = 1; stall_id = 1;
      step();
      check_bubble("flush_sid");
      flush = 0; stall_id = 0;
`ifdef IDEX_PERF_CNT_EN
      check("perf_bubbles", perf_bubbles, 4);
      check("perf_flushes", perf_flushes, 2);
      rst = 1'b1;
      #1 check("perf_rst", perf_bubbles, 0);
      rst = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- Pipeline register between decode (ID) and execute (EX) in the 5-stage MIPS core.
- Captures decoder outputs: operand_1/operand_2, ALU control, memory control, write-back control, store data and instruction address.
- Handles stall, bubble and flush.
- Detects load-use hazards against the instruction currently in EX and raises a stall request to the pipeline controller.

Parameters:
- ADDR_W, 32, instruction address width
- DATA_W, 32, operand/data width
- REG_W, 5, register index width
- ALUOP_W, 8, ALU control code width

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall_id  in  1  ID stage held this cycle
- stall_ex  in  1  EX stage held this cycle
- flush  in  1  discard the instruction being passed to EX (exception/branch redirect)
- id_valid  in  1  ID holds a real instruction
- id_addr  in  ADDR_W  ID instruction address
- id_operand_1  in  DATA_W  from operand generator
- id_operand_2  in  DATA_W  from operand generator
- id_alu_op  in  ALUOP_W  ALU control
- id_mem_read  in  1  load
- id_mem_write  in  1  store
- id_mem_size  in  2  0=byte 1=half 2=word
- id_mem_sign  in  1  sign-extend load
- id_store_data  in  DATA_W  rt value for stores
- id_wb_en  in  1  register write enable
- id_wb_reg  in  REG_W  destination register
- id_rs_read  in  1  ID reads rs
- id_rs  in  REG_W  rs index
- id_rt_read  in  1  ID reads rt
- id_rt  in  REG_W  rt index
- ex_valid, ex_addr, ex_operand_1, ex_operand_2, ex_alu_op, ex_mem_read, ex_mem_write, ex_mem_size, ex_mem_sign, ex_store_data, ex_wb_en, ex_wb_reg  out  (widths as inputs)  registered copies
- load_use_stall  out  1  combinational stall request

Behaviour:
- Reset, asynchronous, while rst=1: all ex_* outputs are 0, which is a bubble.
- Update priority at each rising clk edge, highest first:
  - flush=1: load bubble. All ex_* = 0, ex_valid = 0.
  - stall_ex=1: hold all ex_* outputs.
  - stall_id=1, stall_ex=0: load bubble, so EX proceeds with a NOP.
  - otherwise: capture id_* into ex_*. ex_valid = id_valid. If id_valid=0, all control fields (mem_read, mem_write, wb_en) are forced to 0.
- Latency: one cycle from ID input to EX output.
- Bubble invariant: ex_valid=0 implies ex_mem_read = ex_mem_write = ex_wb_en = 0. Datapath fields are 0.
- Writes to $0: if id_wb_reg=0, ex_wb_en is captured as 0.
- load_use_stall = ex_valid & ex_mem_read & ex_wb_en & (ex_wb_reg≠0) & id_valid & ((id_rs_read & id_rs==ex_wb_reg) | (id_rt_read & id_rt==ex_wb_reg)).
  - The controller turns this into stall_id=1, stall_ex=0. That inserts exactly one bubble, after which the load has left EX and the request drops.
- Simultaneous flush and stall_ex: flush wins.
- Reset mid-stall: the register clears immediately and the stall state is not retained.

Optional Feature:
- Macro: IDEX_PERF_CNT_EN.
- When defined, adds two outputs:
  - perf_bubbles, 32 bits: increments on each edge that loads a bubble because of stall_id (not flush).
  - perf_flushes, 32 bits: increments on each edge with flush=1.
- Both counters wrap modulo 2^32 and reset to 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Bus widths, ALU op codes and mem size codes live in the shared headers (bus.v and the ALU-op header) and are reused here.
- One natural sub-module: load_use_detect, the pure combinational comparator for load_use_stall. It can be reused by a future forwarding unit.
- The register body stays in id_ex_reg.

Test Plan:
- Reset: assert rst mid-cycle with ex_valid=1 -> all ex_* read 0 immediately, without waiting for a clock edge.
- Pass-through: id_valid=1, operand_1=0x00400008, operand_2=0xFFFF8000, wb_reg=5 -> same values on ex_* after one edge, ex_valid=1.
- Load-use:
  - Stimulus: lw with wb_reg=8 is in EX; ID has id_rs_read=1, id_rs=8.
  - Required: load_use_stall=1. With stall_id=1 applied -> next cycle ex_valid=0 and load_use_stall=0.
- $0 load: lw with wb_reg=0 in EX; ID reads rs=0 -> load_use_stall=0, and the captured ex_wb_en was 0.
- Hold vs flush:
  - stall_ex=1 for 3 cycles -> ex_* unchanged.
  - Then flush=1 together with stall_ex=1 -> bubble on the next edge.
- Perf counters (IDEX_PERF_CNT_EN defined): 4 stall_id bubbles and 2 flushes -> perf_bubbles=4, perf_flushes=2.
